// File: rtl/morty_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes,
// exception codes and the LSU control states.
package morty_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  localparam logic [3:0] EXC_NONE   = 4'd0;
  localparam logic [3:0] EXC_LD_MIS = 4'd4;
  localparam logic [3:0] EXC_LD_FLT = 4'd5;
  localparam logic [3:0] EXC_ST_MIS = 4'd6;
  localparam logic [3:0] EXC_ST_FLT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_DONE,
    ST_DRAIN
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath for the LSU: alignment/size checks, store byte-lane
// steering, and load shift with sign/zero extension.
module lsu_align
  import morty_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic        illegal,
  output logic [3:0]  sel,
  output logic [31:0] dat,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    sel        = '0;
    dat        = '0;
    ld_data    = '0;
    shifted    = rdata >> {off, 3'b000};
    case (size)
      SZ_B: begin
        sel     = 4'b0001 << off;
        dat     = {4{wdata[7:0]}};
        ld_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        misaligned = off[0];
        sel        = off[1] ? 4'b1100 : 4'b0011;
        dat        = {2{wdata[15:0]}};
        ld_data    = {{16{~uns & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        misaligned = |off;
        sel        = 4'b1111;
        dat        = wdata;
        ld_data    = shifted;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one Wishbone-classic data-bus cycle per
// EX/MEM operation and presents extended load data plus an exception code.
module mem_lsu
  import morty_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid_i,
  input  logic          ex_we_i,
  input  logic [1:0]    ex_size_i,
  input  logic          ex_unsigned_i,
  input  logic [AW-1:0] ex_addr_i,
  input  logic [31:0]   ex_wdata_i,
  input  logic          kill_i,
  output logic          dbus_cyc_o,
  output logic          dbus_stb_o,
  output logic          dbus_we_o,
  output logic [AW-1:0] dbus_addr_o,
  output logic [3:0]    dbus_sel_o,
  output logic [31:0]   dbus_dat_o,
  input  logic [31:0]   dbus_dat_i,
  input  logic          dbus_ack_i,
  input  logic          dbus_err_i,
  output logic [31:0]   ld_data_o,
  output logic [3:0]    exc_o,
  output logic          done_o,
  output logic          stall_o
);

  lsu_state_e  state_q, state_d;

  logic          cyc_q, cyc_d, we_q, we_d, done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    sel_q, sel_d, exc_q, exc_d;
  logic [31:0]   dat_q, dat_d, ld_q, ld_d;

  logic          op_we_q, op_we_d, op_uns_q, op_uns_d;
  size_e         op_size_q, op_size_d;
  logic [1:0]    op_off_q, op_off_d;

  size_e         a_size;
  logic [1:0]    a_off;
  logic          a_uns;
  logic          misaligned, illegal;
  logic [3:0]    a_sel;
  logic [31:0]   a_dat, a_ld;

  // The aligner sees the incoming op while idle and the latched op afterwards,
  // so load extension does not depend on EX/MEM staying frozen.
  always_comb begin
    if (state_q == ST_IDLE) begin
      a_size = size_e'(ex_size_i);
      a_off  = ex_addr_i[1:0];
      a_uns  = ex_unsigned_i;
    end else begin
      a_size = op_size_q;
      a_off  = op_off_q;
      a_uns  = op_uns_q;
    end
  end

  lsu_align u_align (
    .size       (a_size),
    .off        (a_off),
    .uns        (a_uns),
    .wdata      (ex_wdata_i),
    .rdata      (dbus_dat_i),
    .misaligned (misaligned),
    .illegal    (illegal),
    .sel        (a_sel),
    .dat        (a_dat),
    .ld_data    (a_ld)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    ld_d      = ld_q;
    exc_d     = EXC_NONE;
    done_d    = 1'b0;
    op_we_d   = op_we_q;
    op_uns_d  = op_uns_q;
    op_size_d = op_size_q;
    op_off_d  = op_off_q;
    stall_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid_i && !kill_i) begin
          stall_o = 1'b1;
          if (illegal || misaligned) begin
            ld_d    = '0;
            done_d  = 1'b1;
            state_d = ST_DONE;
            if (illegal) exc_d = ex_we_i ? EXC_ST_FLT : EXC_LD_FLT;
            else         exc_d = ex_we_i ? EXC_ST_MIS : EXC_LD_MIS;
          end else begin
            cyc_d     = 1'b1;
            we_d      = ex_we_i;
            addr_d    = {ex_addr_i[AW-1:2], 2'b00};
            sel_d     = a_sel;
            dat_d     = a_dat;
            op_we_d   = ex_we_i;
            op_uns_d  = ex_unsigned_i;
            op_size_d = size_e'(ex_size_i);
            op_off_d  = ex_addr_i[1:0];
            state_d   = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        stall_o = 1'b1;
        if (dbus_ack_i || dbus_err_i) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (kill_i) begin
            state_d = ST_IDLE;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
            if (dbus_err_i) begin
              ld_d  = '0;
              exc_d = op_we_q ? EXC_ST_FLT : EXC_LD_FLT;
            end else begin
              ld_d  = op_we_q ? '0 : a_ld;
            end
          end
        end else if (kill_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        stall_o = ex_valid_i;
        if (dbus_ack_i || dbus_err_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      sel_q     <= '0;
      dat_q     <= '0;
      ld_q      <= '0;
      exc_q     <= EXC_NONE;
      done_q    <= 1'b0;
      op_we_q   <= 1'b0;
      op_uns_q  <= 1'b0;
      op_size_q <= SZ_B;
      op_off_q  <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      ld_q      <= ld_d;
      exc_q     <= exc_d;
      done_q    <= done_d;
      op_we_q   <= op_we_d;
      op_uns_q  <= op_uns_d;
      op_size_q <= op_size_d;
      op_off_q  <= op_off_d;
    end
  end

  assign dbus_cyc_o  = cyc_q;
  assign dbus_stb_o  = cyc_q;
  assign dbus_we_o   = we_q;
  assign dbus_addr_o = addr_q;
  assign dbus_sel_o  = sel_q;
  assign dbus_dat_o  = dat_q;
  assign ld_data_o   = ld_q;
  assign exc_o       = exc_q;
  assign done_o      = done_q;

endmodule
